reg_file_wb: RTL and testbench
==============================

# reg_file_wb

Architectural register file with a single write-back port, two combinational read ports and a sequential register-dump port. It is the consumer end of the write-back path: it receives the destination-register index and the write-back data selected upstream, and commits them on the clock edge. The dump port streams all registers out under a valid/ready handshake for debug and self-check benches.

## Interface
- DATA_W, 32: register width in bits
- ADDR_W, 5: register index width
- NREG, 32: number of registers (2**ADDR_W); register 0 is hardwired to zero

- clk  in  1  clock; all state updates on rising edge
- rst_n  in  1  asynchronous, active-low reset
- we  in  1  write enable
- waddr  in  ADDR_W  write-back destination index
- wdata  in  DATA_W  write-back data
- raddr_a, raddr_b  in  ADDR_W  read indices
- rdata_a, rdata_b  out  DATA_W  combinational read data
- dump_start  in  1  request a full register dump (sampled in IDLE only)
- dump_valid  out  1  dump_addr/dump_data are valid
- dump_ready  in  1  downstream accepts the current dump beat
- dump_addr  out  ADDR_W  index of current dump beat
- dump_data  out  DATA_W  contents of that register
- dump_busy  out  1  high in SCAN and DONE
- dump_done  out  1  one-cycle pulse after the last beat is accepted

## Operation
- Reset (asynchronous, rst_n=0): all registers cleared to 0; FSM to IDLE; dump_valid=0, dump_busy=0, dump_done=0, dump_addr=0, dump_data=0.
- Write: on rising edge with we=1 and waddr!=0, reg[waddr] <= wdata. Writes to index 0 are discarded.
- Read: rdata_x = 0 if raddr_x==0; else wdata if we=1 and waddr==raddr_x (same-cycle bypass); else reg[raddr_x].
- Dump FSM states: IDLE, SCAN, DONE.
  - IDLE: dump_start=1 -> SCAN; dump_addr<=0, dump_data<=0 (register 0), dump_valid<=1.
  - SCAN: beat accepted when dump_valid & dump_ready. On acceptance with dump_addr==NREG-1 -> DONE, dump_valid<=0. Otherwise dump_addr<=dump_addr+1 and dump_data<=bypassed read of the new index (includes a write committed on that same edge).
  - DONE: dump_done=1 for exactly one cycle -> IDLE.
- dump_start is ignored in SCAN and DONE; no queuing.
- dump_addr/dump_data are registered and held stable while dump_valid=1 and dump_ready=0, even if the register being presented is written in the meantime; the dump beat reflects the value at the moment the beat was loaded.
- Writes and reads proceed normally during a dump; the dump never stalls the write port.

## Timing
- Write latency: wdata visible in reg[] the cycle after the edge; visible on rdata in the same cycle via bypass.
- dump_start high at edge N -> dump_valid=1, dump_addr=0 from cycle N+1.
- With dump_ready held 1: one beat per cycle, addresses 0..31 in cycles N+1..N+32; dump_done=1 in cycle N+33; IDLE at N+34; dump_busy=1 from N+1 through N+33.
- Back-pressure: each cycle of dump_ready=0 extends the dump by one cycle; no beats dropped or duplicated.
- Reset asserted mid-dump: FSM returns to IDLE immediately, dump_valid drops asynchronously, no dump_done pulse.

## Test plan
- Reset then read all indices -> rdata_a/rdata_b = 0 for every raddr; dump_valid=0, dump_busy=0.
- Write 0xDEADBEEF to reg 5, then we=1 waddr=0 wdata=0x12345678 -> reg 5 reads 0xDEADBEEF, reg 0 reads 0; same-cycle raddr_a=5 with we=1 waddr=5 wdata=0xA5A5A5A5 -> rdata_a=0xA5A5A5A5 before the edge.
- Load reg[i]=i*0x01010101, dump with dump_ready=1 -> 32 beats, dump_addr 0..31, dump_data 0, 0x01010101, ..., 0x1F1F1F1F, dump_done pulse in cycle N+33.
- Dump with dump_ready toggling 1,0,0,1,... -> every index delivered exactly once in order; data held stable during stalls; write to currently presented index during stall does not change dump_data.
- dump_start pulsed during SCAN -> ignored; exactly one dump_done per accepted start.
- rst_n=0 at beat 10 of a dump -> dump_valid=0 immediately, registers cleared, no dump_done; new dump_start afterwards yields 32 zero beats.

Source files
------------

// File: rtl/reg_file_wb.sv
// Architectural register file: one write-back port, two bypassed read ports and
// a valid/ready register-dump port that streams every register out in order.
module reg_file_wb #(
    parameter int DATA_W = 32,
    parameter int ADDR_W = 5,
    parameter int NREG   = 32
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              we,
    input  logic [ADDR_W-1:0] waddr,
    input  logic [DATA_W-1:0] wdata,
    input  logic [ADDR_W-1:0] raddr_a,
    input  logic [ADDR_W-1:0] raddr_b,
    output logic [DATA_W-1:0] rdata_a,
    output logic [DATA_W-1:0] rdata_b,
    input  logic              dump_start,
    output logic              dump_valid,
    input  logic              dump_ready,
    output logic [ADDR_W-1:0] dump_addr,
    output logic [DATA_W-1:0] dump_data,
    output logic              dump_busy,
    output logic              dump_done
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        SCAN = 2'd1,
        DONE = 2'd2
    } state_e;

    localparam logic [DATA_W-1:0] ZERO_DATA = {DATA_W{1'b0}};
    localparam logic [ADDR_W-1:0] ZERO_ADDR = {ADDR_W{1'b0}};
    localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(NREG - 1);

    logic [DATA_W-1:0] regs_q [NREG];
    logic [DATA_W-1:0] regs_d [NREG];

    state_e            state_q, state_d;
    logic [ADDR_W-1:0] dump_addr_q, dump_addr_d;
    logic [DATA_W-1:0] dump_data_q, dump_data_d;
    logic              dump_valid_q, dump_valid_d;
    logic              dump_busy_q, dump_busy_d;
    logic              dump_done_q, dump_done_d;
    logic [ADDR_W-1:0] next_addr_s;

    // Register 0 reads as zero; a write in flight to the index is forwarded.
    function automatic logic [DATA_W-1:0] bypass_read(input logic [ADDR_W-1:0] a);
        logic [DATA_W-1:0] r;
        if (a == ZERO_ADDR) begin
            r = ZERO_DATA;
        end else if (we && (waddr == a)) begin
            r = wdata;
        end else begin
            r = regs_q[a];
        end
        return r;
    endfunction

    // Combinational read ports
    always_comb begin
        rdata_a = bypass_read(raddr_a);
        rdata_b = bypass_read(raddr_b);
    end

    // Next register contents; index 0 is never written
    always_comb begin
        regs_d = regs_q;
        if (we && (waddr != ZERO_ADDR)) begin
            regs_d[waddr] = wdata;
        end else begin
            regs_d[0] = ZERO_DATA;
        end
    end

    // Dump FSM next-state and registered-output logic
    always_comb begin
        state_d     = state_q;
        dump_addr_d = dump_addr_q;
        dump_data_d = dump_data_q;
        dump_valid_d = dump_valid_q;
        dump_busy_d = dump_busy_q;
        dump_done_d = 1'b0;
        next_addr_s = dump_addr_q + ADDR_W'(1);
        case (state_q)
            IDLE: begin
                if (dump_start) begin
                    state_d      = SCAN;
                    dump_addr_d  = ZERO_ADDR;
                    dump_data_d  = ZERO_DATA;
                    dump_valid_d = 1'b1;
                    dump_busy_d  = 1'b1;
                end else begin
                    dump_valid_d = 1'b0;
                    dump_busy_d  = 1'b0;
                end
            end
            SCAN: begin
                if (dump_ready) begin
                    if (dump_addr_q == LAST_ADDR) begin
                        state_d      = DONE;
                        dump_valid_d = 1'b0;
                        dump_done_d  = 1'b1;
                    end else begin
                        // The new beat captures any write landing on this same edge
                        dump_addr_d = next_addr_s;
                        dump_data_d = bypass_read(next_addr_s);
                    end
                end else begin
                    dump_valid_d = 1'b1;
                end
            end
            DONE: begin
                state_d     = IDLE;
                dump_busy_d = 1'b0;
            end
            default: begin
                state_d      = IDLE;
                dump_valid_d = 1'b0;
                dump_busy_d  = 1'b0;
            end
        endcase
    end

    // State registers: register array and dump FSM
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < NREG; i++) begin
                regs_q[i] <= ZERO_DATA;
            end
            state_q      <= IDLE;
            dump_addr_q  <= ZERO_ADDR;
            dump_data_q  <= ZERO_DATA;
            dump_valid_q <= 1'b0;
            dump_busy_q  <= 1'b0;
            dump_done_q  <= 1'b0;
        end else begin
            regs_q       <= regs_d;
            state_q      <= state_d;
            dump_addr_q  <= dump_addr_d;
            dump_data_q  <= dump_data_d;
            dump_valid_q <= dump_valid_d;
            dump_busy_q  <= dump_busy_d;
            dump_done_q  <= dump_done_d;
        end
    end

    assign dump_valid = dump_valid_q;
    assign dump_addr  = dump_addr_q;
    assign dump_data  = dump_data_q;
    assign dump_busy  = dump_busy_q;
    assign dump_done  = dump_done_q;

endmodule

// File: tb/tb_reg_file_wb.sv
// Bench for reg_file_wb: table-driven read/write vectors plus a dump scoreboard
// covering full-rate, back-pressured, ignored-restart and mid-dump reset cases.
module tb_reg_file_wb;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        we = 1'b0;
    logic [4:0]  waddr = 5'd0;
    logic [31:0] wdata = 32'd0;
    logic [4:0]  raddr_a = 5'd0;
    logic [4:0]  raddr_b = 5'd0;
    logic [31:0] rdata_a, rdata_b;
    logic        dump_start = 1'b0;
    logic        dump_valid;
    logic        dump_ready = 1'b0;
    logic [4:0]  dump_addr;
    logic [31:0] dump_data;
    logic        dump_busy, dump_done;

    reg_file_wb dut (
        .clk(clk), .rst_n(rst_n), .we(we), .waddr(waddr), .wdata(wdata),
        .raddr_a(raddr_a), .raddr_b(raddr_b), .rdata_a(rdata_a), .rdata_b(rdata_b),
        .dump_start(dump_start), .dump_valid(dump_valid), .dump_ready(dump_ready),
        .dump_addr(dump_addr), .dump_data(dump_data), .dump_busy(dump_busy),
        .dump_done(dump_done)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic        we;
        logic [4:0]  waddr;
        logic [31:0] wdata;
        logic [4:0]  ra;
        logic [4:0]  rb;
        logic [31:0] ea;
        logic [31:0] eb;
    } vec_t;

    typedef struct {
        logic [4:0]  a;
        logic [31:0] d;
    } beat_t;

    vec_t        vecs [7];
    beat_t       sb [$];
    logic [31:0] model [32];
    int          tests = 0;
    int          fails = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
        end
    endtask

    task automatic start_dump();
        @(negedge clk);
        we = 1'b0;
        dump_start = 1'b1;
        for (int i = 0; i < 32; i++) begin
            sb.push_back('{a: 5'(i), d: model[i]});
        end
    endtask

    // mode 0: ready always 1; mode 1: ready 1,0,0 repeating with a stall write; mode 2: restart pulse mid-scan
    task automatic run_dump(input int ncyc, input int mode, output int done_cycle, output int done_cnt);
        bit stall_written = 1'b0;
        done_cycle = -1;
        done_cnt = 0;
        for (int c = 1; c <= ncyc; c++) begin
            @(negedge clk);
            dump_start = (mode == 2 && c == 5) ? 1'b1 : 1'b0;
            we = 1'b0;
            dump_ready = (mode == 1) ? ((c % 3) == 1) : 1'b1;
            if (mode == 1 && !stall_written && (c % 3) == 2 && c > 6 && sb.size() > 0 && sb[0].a != 5'd0) begin
                we = 1'b1;
                waddr = sb[0].a;
                wdata = 32'hCAFEF00D;
                model[sb[0].a] = 32'hCAFEF00D;
                stall_written = 1'b1;
            end
            #1;
            if (dump_valid) begin
                if (sb.size() == 0) begin
                    chk("extra_beat", 32'(dump_addr), 32'hFFFFFFFF);
                end else begin
                    chk("dump_addr", 32'(dump_addr), 32'(sb[0].a));
                    chk("dump_data", dump_data, sb[0].d);
                    if (dump_ready) void'(sb.pop_front());
                end
            end
            if (dump_done) begin
                done_cnt++;
                if (done_cycle < 0) done_cycle = c;
            end
            if (mode == 0 && (c == 1 || c == 33)) chk("busy_high", 32'(dump_busy), 32'd1);
            if (mode == 0 && c == 34) chk("busy_low", 32'(dump_busy), 32'd0);
        end
        @(negedge clk);
        we = 1'b0;
        dump_start = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        int dc, dn;
        bit hit;

        vecs[0] = '{1'b1, 5'd5,  32'hDEADBEEF, 5'd5,  5'd0, 32'hDEADBEEF, 32'h0};
        vecs[1] = '{1'b1, 5'd0,  32'h12345678, 5'd0,  5'd5, 32'h0,        32'hDEADBEEF};
        vecs[2] = '{1'b0, 5'd0,  32'h0,        5'd5,  5'd0, 32'hDEADBEEF, 32'h0};
        vecs[3] = '{1'b1, 5'd5,  32'hA5A5A5A5, 5'd5,  5'd5, 32'hA5A5A5A5, 32'hA5A5A5A5};
        vecs[4] = '{1'b0, 5'd0,  32'h0,        5'd5,  5'd1, 32'hA5A5A5A5, 32'h0};
        vecs[5] = '{1'b1, 5'd31, 32'hFFFFFFFF, 5'd31, 5'd5, 32'hFFFFFFFF, 32'hA5A5A5A5};
        vecs[6] = '{1'b0, 5'd0,  32'h0,        5'd31, 5'd30, 32'hFFFFFFFF, 32'h0};
        for (int i = 0; i < 32; i++) model[i] = 32'd0;

        // Reset state: every register reads zero, dump port idle
        repeat (2) @(negedge clk);
        for (int i = 0; i < 32; i++) begin
            raddr_a = 5'(i);
            raddr_b = 5'(31 - i);
            #1;
            chk("rst_rdata_a", rdata_a, 32'h0);
            chk("rst_rdata_b", rdata_b, 32'h0);
        end
        chk("rst_valid", 32'(dump_valid), 32'd0);
        chk("rst_busy", 32'(dump_busy), 32'd0);
        chk("rst_done", 32'(dump_done), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;

        // Table vectors: write, discard to reg 0, same-cycle bypass
        for (int i = 0; i < 7; i++) begin
            @(negedge clk);
            we = vecs[i].we;
            waddr = vecs[i].waddr;
            wdata = vecs[i].wdata;
            raddr_a = vecs[i].ra;
            raddr_b = vecs[i].rb;
            #1;
            chk("vec_rdata_a", rdata_a, vecs[i].ea);
            chk("vec_rdata_b", rdata_b, vecs[i].eb);
        end

        // Load reg[i] = i * 0x01010101
        for (int i = 1; i < 32; i++) begin
            @(negedge clk);
            we = 1'b1;
            waddr = 5'(i);
            wdata = 32'(i) * 32'h01010101;
            model[i] = wdata;
        end
        @(negedge clk);
        we = 1'b0;

        // Full-rate dump
        start_dump();
        run_dump(40, 0, dc, dn);
        chk("fast_done_cycle", 32'(dc), 32'd33);
        chk("fast_done_cnt", 32'(dn), 32'd1);
        chk("fast_sb_empty", 32'(sb.size()), 32'd0);

        // Back-pressured dump with a write to the presented index during a stall
        start_dump();
        run_dump(110, 1, dc, dn);
        chk("bp_done_cnt", 32'(dn), 32'd1);
        chk("bp_sb_empty", 32'(sb.size()), 32'd0);

        // Restart pulse during scan is ignored
        start_dump();
        run_dump(80, 2, dc, dn);
        chk("restart_done_cnt", 32'(dn), 32'd1);
        chk("restart_sb_empty", 32'(sb.size()), 32'd0);

        // Reset at beat 10 of a dump
        start_dump();
        hit = 1'b0;
        for (int c = 0; c < 50 && !hit; c++) begin
            @(negedge clk);
            dump_start = 1'b0;
            dump_ready = 1'b1;
            #1;
            if (sb.size() > 0 && sb[0].a == 5'd10) begin
                hit = 1'b1;
            end else if (dump_valid && sb.size() > 0) begin
                chk("pre_rst_addr", 32'(dump_addr), 32'(sb[0].a));
                void'(sb.pop_front());
            end
        end
        chk("rst_beat10_reached", 32'(hit), 32'd1);
        chk("mid_valid_before", 32'(dump_valid), 32'd1);
        rst_n = 1'b0;
        raddr_a = 5'd10;
        raddr_b = 5'd31;
        #1;
        chk("mid_rst_valid", 32'(dump_valid), 32'd0);
        chk("mid_rst_busy", 32'(dump_busy), 32'd0);
        chk("mid_rst_rdata_a", rdata_a, 32'h0);
        chk("mid_rst_rdata_b", rdata_b, 32'h0);
        sb.delete();
        for (int i = 0; i < 32; i++) model[i] = 32'd0;
        @(negedge clk);
        rst_n = 1'b1;
        dn = 0;
        for (int c = 0; c < 5; c++) begin
            @(negedge clk);
            #1;
            if (dump_done) dn++;
        end
        chk("mid_rst_no_done", 32'(dn), 32'd0);
        start_dump();
        run_dump(40, 0, dc, dn);
        chk("post_rst_done_cycle", 32'(dc), 32'd33);
        chk("post_rst_done_cnt", 32'(dn), 32'd1);
        chk("post_rst_sb_empty", 32'(sb.size()), 32'd0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
